// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_pkg;

    localparam int DEF_CLK_FREQ_HZ = 25_000_000;
    localparam int DEF_BAUD_RATE   = 115_200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte bus: single-cycle strobe plus the byte it qualifies.
interface uart_rx_if;
    logic       wr_o;
    logic [7:0] data_o;

    modport master (output wr_o, output data_o);
    modport slave  (input wr_o, input data_o);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets (and powers up) to 1.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta = 1'b1;
    logic sync = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the serial line, samples mid-bit, emits one strobe per good frame.
//
// state | meaning
// IDLE  | waiting for the synchronized line to be low
// START | counting to the middle of the start bit to reject glitches
// DATA  | sampling 8 data bits LSB first at mid-bit
// STOP  | sampling the stop bit; publishes the byte only if it is high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int BAUD_RATE   = DEF_BAUD_RATE
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      uart_rx_i,
    uart_rx_if.master rx_if
);

    localparam int          CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST    = 16'((CLKS_PER_BIT / 2) - 1);

    logic rx_s;

    state_t      state_q = IDLE;
    state_t      state_d;
    logic [15:0] cnt_q   = '0;
    logic [15:0] cnt_d;
    logic [2:0]  idx_q   = '0;
    logic [2:0]  idx_d;
    logic [7:0]  shift_q = '0;
    logic [7:0]  shift_d;
    logic [7:0]  data_q  = '0;
    logic [7:0]  data_d;
    logic        wr_q    = 1'b0;
    logic        wr_d;

    sync_2ff u_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (uart_rx_i),
        .q   (rx_s)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        wr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Level-triggered: a line that is already low counts as a start bit.
                if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                // Decided mid stop bit so IDLE is ready before the next start edge.
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d = shift_q;
                        wr_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_if.wr_o   = wr_q;
    assign rx_if.data_o = data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: back-to-back frames, start glitch, framing error, mid-frame reset, strobe timing.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLKS = 217;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b0;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ_HZ (25_000_000),
        .BAUD_RATE   (115_200)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .uart_rx_i (rx),
        .rx_if     (bus)
    );

    always #20 clk = ~clk;

    int         n_cmp = 0;
    int         n_mis = 0;
    int         cyc   = 0;
    int         wr_cyc = 0;
    int         dbl_strobe = 0;
    int         stray_chg  = 0;
    logic       wr_prev   = 1'b0;
    logic [7:0] data_prev = 8'h00;
    logic       rst_pos   = 1'b0;
    logic [7:0] rx_q[$];

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_pos <= rst;
    end

    // Monitor: collect strobed bytes and flag back-to-back strobes or unstrobed data changes.
    always @(negedge clk) begin
        if (bus.wr_o) begin
            rx_q.push_back(bus.data_o);
            wr_cyc <= cyc;
        end
        if (bus.wr_o && wr_prev) dbl_strobe <= dbl_strobe + 1;
        if (!bus.wr_o && (bus.data_o != data_prev) && !rst_pos) stray_chg <= stray_chg + 1;
        wr_prev   <= bus.wr_o;
        data_prev <= bus.data_o;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; start bit begins immediately.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop_bit;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
    endtask

    logic [7:0] b2b_bytes [6] = '{8'd17, 8'd29, 8'd50, 8'd79, 8'd0, 8'd57};
    int base;
    int t0;
    int lat;

    initial begin
        @(negedge clk);
        chk("pwr_wr",   {31'd0, bus.wr_o}, 32'd0);
        chk("pwr_data", {24'd0, bus.data_o}, 32'h00);

        // Line low from t=0 is the first start bit; six frames with no idle gap.
        for (int i = 0; i < 6; i++) send_frame(b2b_bytes[i], 1'b1, BIT_CLKS);
        idle_cycles(20);
        chk("b2b_count", rx_q.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("b2b_byte%0d", i), (rx_q.size() > i) ? {24'd0, rx_q[i]} : 32'hdead, {24'd0, b2b_bytes[i]});
        end

        idle_cycles(300);
        base = rx_q.size();
        rx = 1'b0;
        repeat (50) @(negedge clk);
        idle_cycles(200);
        chk("glitch_nostrobe", rx_q.size(), base);
        chk("glitch_idle", {30'd0, dut.state_q}, {30'd0, IDLE});
        send_frame(8'hA5, 1'b1, BIT_CLKS);
        idle_cycles(20);
        chk("a5_count", rx_q.size(), base + 1);
        chk("a5_data", {24'd0, bus.data_o}, 32'hA5);

        base = rx_q.size();
        send_frame(8'h3C, 1'b0, 160);
        idle_cycles(400);
        chk("fe_nostrobe", rx_q.size(), base);
        chk("fe_data_held", {24'd0, bus.data_o}, 32'hA5);
        send_frame(8'h55, 1'b1, BIT_CLKS);
        idle_cycles(20);
        chk("55_count", rx_q.size(), base + 1);
        chk("55_data", {24'd0, bus.data_o}, 32'h55);

        idle_cycles(100);
        base = rx_q.size();
        fork
            send_frame(8'hFF, 1'b1, BIT_CLKS);
            begin
                repeat (BIT_CLKS * 5 + 108) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_wr",   {31'd0, bus.wr_o}, 32'd0);
                chk("rst_data", {24'd0, bus.data_o}, 32'h00);
            end
        join
        idle_cycles(20);
        chk("rst_nostrobe", rx_q.size(), base);
        send_frame(8'h81, 1'b1, BIT_CLKS);
        idle_cycles(20);
        chk("81_count", rx_q.size(), base + 1);
        chk("81_data", {24'd0, bus.data_o}, 32'h81);

        idle_cycles(50);
        base = rx_q.size();
        t0 = cyc;
        send_frame(8'h01, 1'b1, BIT_CLKS);
        idle_cycles(20);
        chk("01_count", rx_q.size(), base + 1);
        chk("01_data", {24'd0, bus.data_o}, 32'h01);
        lat = wr_cyc - t0;
        // 9.5 bit times = 2061.5 cycles, allow +/-3 cycles.
        chk("01_latency_window", {31'd0, (lat >= 2058 && lat <= 2065)}, 32'd1);
        idle_cycles(500);
        chk("01_data_hold", {24'd0, bus.data_o}, 32'h01);
        chk("dbl_strobe", dbl_strobe, 32'd0);
        chk("stray_data_change", stray_chg, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
